// File: rtl/hdmi_pll_supervisor_pkg.sv
`default_nettype none
// ============================================================================
// hdmi_pll_supervisor_pkg : state encodings, default timing, output decode
// Rev 1.0
// ============================================================================
package hdmi_pll_supervisor_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        REL_SER   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } pll_state_t;

    localparam int unsigned DEF_PLL_RST_CYCLES = 16;
    localparam int unsigned DEF_LOCK_STABLE    = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 270000;
    localparam int unsigned DEF_SER_TO_PIX     = 32;
    localparam int unsigned DEF_MAX_RETRY      = 7;
    localparam int unsigned DEF_TW             = 19;

    typedef struct packed {
        logic pll_reset;
        logic ser_reset;
        logic pix_reset;
        logic locked;
        logic fault;
    } sup_outs_t;

    // Reset ordering lives here so every consumer decodes states identically.
    function automatic sup_outs_t decode_outputs(input pll_state_t s);
        sup_outs_t o;
        o.pll_reset = (s == PLL_RST) || (s == FAULT);
        o.ser_reset = !((s == REL_SER) || (s == RUN));
        o.pix_reset = (s != RUN);
        o.locked    = (s == RUN);
        o.fault     = (s == FAULT);
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_pll_supervisor_sync2_ff.sv
`default_nettype none
// ============================================================================
// sync2_ff : generic two-flop synchronizer for asynchronous inputs
// Rev 1.0
// ============================================================================
module sync2_ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule
`default_nettype wire

// File: rtl/hdmi_pll_supervisor.sv
`default_nettype none
// ============================================================================
// hdmi_pll_supervisor : rPLL lock supervisor and ordered reset sequencer
// Rev 1.0
// ============================================================================
module hdmi_pll_supervisor
    import hdmi_pll_supervisor_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_STABLE    = DEF_LOCK_STABLE,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned SER_TO_PIX     = DEF_SER_TO_PIX,
    parameter int unsigned MAX_RETRY      = DEF_MAX_RETRY,
    parameter int unsigned TW             = DEF_TW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock_i,
    input  logic       relock_req,
    output logic       pll_reset_o,
    output logic       ser_reset_o,
    output logic       pix_reset_o,
    output logic       locked_o,
    output logic       fault_o,
    output logic [3:0] retry_cnt_o
);
    localparam int unsigned CW = TW + 1;
    localparam logic [TW-1:0] RST_LAST     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] SER_LAST     = TW'(SER_TO_PIX - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

    pll_state_t    state;
    pll_state_t    next_state;
    pll_state_t    timeout_state;
    logic [TW-1:0] timer;
    logic [TW-1:0] stable_cnt;
    logic [3:0]    retry_cnt;
    logic [3:0]    next_retry;
    logic [3:0]    retry_inc;
    logic          lock_s;
    logic          restart;
    logic          timed_out;
    logic          stable_done;
    logic          keep_timer;

    sync2_ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock_i),
        .q     (lock_s)
    );

    assign retry_inc     = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;
    assign timeout_state = (retry_inc == RETRY_LIMIT) ? FAULT : PLL_RST;
    assign timed_out     = (timer == TIMEOUT_LAST);
    // The lock sample that moved WAIT_LOCK into STABLE counts toward the run.
    assign stable_done   = lock_s && (({1'b0, stable_cnt} + CW'(1)) >= STABLE_LAST);
    // The timeout window spans both lock-waiting states.
    assign keep_timer    = ((state == WAIT_LOCK) || (state == STABLE)) &&
                           ((next_state == WAIT_LOCK) || (next_state == STABLE));
    assign retry_cnt_o   = retry_cnt;

    always_comb begin
        next_state = state;
        next_retry = retry_cnt;
        restart    = 1'b0;
        if (relock_req) begin
            next_state = PLL_RST;
            next_retry = 4'd0;
            restart    = 1'b1;
        end else begin
            case (state)
                PLL_RST: begin
                    if (timer == RST_LAST) next_state = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (timed_out) begin
                        next_retry = retry_inc;
                        next_state = timeout_state;
                    end else if (lock_s) begin
                        next_state = STABLE;
                    end
                end
                STABLE: begin
                    if (stable_done) begin
                        next_state = REL_SER;
                    end else if (timed_out) begin
                        next_retry = retry_inc;
                        next_state = timeout_state;
                    end else if (!lock_s) begin
                        next_state = WAIT_LOCK;
                    end
                end
                REL_SER: begin
                    if (!lock_s) begin
                        next_state = PLL_RST;
                    end else if (timer == SER_LAST) begin
                        next_state = RUN;
                        next_retry = 4'd0;
                    end
                end
                RUN: begin
                    if (!lock_s) next_state = PLL_RST;
                end
                FAULT:   next_state = FAULT;
                default: next_state = PLL_RST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PLL_RST;
            timer      <= '0;
            stable_cnt <= '0;
            retry_cnt  <= 4'd0;
            {pll_reset_o, ser_reset_o, pix_reset_o, locked_o, fault_o} <= decode_outputs(PLL_RST);
        end else begin
            state     <= next_state;
            retry_cnt <= next_retry;
            if (restart || ((next_state != state) && !keep_timer)) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + TW'(1);
            end
            if ((state == STABLE) && (next_state == STABLE)) begin
                stable_cnt <= stable_cnt + TW'(1);
            end else begin
                stable_cnt <= '0;
            end
            {pll_reset_o, ser_reset_o, pix_reset_o, locked_o, fault_o} <= decode_outputs(next_state);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hdmi_pll_supervisor.sv
`default_nettype none
// ============================================================================
// tb_hdmi_pll_supervisor : directed vector table plus randomized run checked
// against a phase-level reference model; reset-ordering invariants every cycle
// Rev 1.0
// ============================================================================
module tb_hdmi_pll_supervisor;
    localparam int PRC = 4;
    localparam int LS  = 8;
    localparam int LT  = 100;
    localparam int STP = 3;
    localparam int MR  = 3;

    logic       clk;
    logic       reset;
    logic       pll_lock_i;
    logic       relock_req;
    logic       pll_reset_o;
    logic       ser_reset_o;
    logic       pix_reset_o;
    logic       locked_o;
    logic       fault_o;
    logic [3:0] retry_cnt_o;

    int checks = 0;
    int errors = 0;

    hdmi_pll_supervisor #(
        .PLL_RST_CYCLES (PRC),
        .LOCK_STABLE    (LS),
        .LOCK_TIMEOUT   (LT),
        .SER_TO_PIX     (STP),
        .MAX_RETRY      (MR),
        .TW             (19)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock_i  (pll_lock_i),
        .relock_req  (relock_req),
        .pll_reset_o (pll_reset_o),
        .ser_reset_o (ser_reset_o),
        .pix_reset_o (pix_reset_o),
        .locked_o    (locked_o),
        .fault_o     (fault_o),
        .retry_cnt_o (retry_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: WAIT_LOCK and STABLE collapse into one waiting phase
    // tracked by a run length of consecutive synchronized lock samples.
    localparam int PH_HOLD = 0, PH_WAIT = 1, PH_REL = 2, PH_RUN = 3, PH_FAULT = 4;
    int m_phase = PH_HOLD;
    int m_age   = 0;
    int m_run   = 0;
    int m_retry = 0;
    bit m_sync0 = 1'b0;
    bit m_sync1 = 1'b0;

    task automatic model_step();
        bit ls;
        ls = m_sync1;
        if (reset) begin
            m_phase = PH_HOLD; m_age = 0; m_run = 0; m_retry = 0;
            m_sync0 = 1'b0; m_sync1 = 1'b0;
        end else begin
            m_sync1 = m_sync0;
            m_sync0 = pll_lock_i;
            if (relock_req) begin
                m_phase = PH_HOLD; m_age = 0; m_retry = 0;
            end else begin
                case (m_phase)
                    PH_HOLD: begin
                        if (m_age == PRC - 1) begin m_phase = PH_WAIT; m_age = 0; m_run = 0; end
                        else m_age++;
                    end
                    PH_WAIT: begin
                        m_run = ls ? m_run + 1 : 0;
                        if (m_run >= LS) begin
                            m_phase = PH_REL; m_age = 0;
                        end else if (m_age == LT - 1) begin
                            m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                            m_phase = (m_retry == MR) ? PH_FAULT : PH_HOLD;
                            m_age   = 0;
                        end else begin
                            m_age++;
                        end
                    end
                    PH_REL: begin
                        if (!ls) begin m_phase = PH_HOLD; m_age = 0; end
                        else if (m_age == STP - 1) begin m_phase = PH_RUN; m_retry = 0; m_age = 0; end
                        else m_age++;
                    end
                    PH_RUN: begin
                        if (!ls) begin m_phase = PH_HOLD; m_age = 0; end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {pll_reset_o, ser_reset_o, pix_reset_o, locked_o, fault_o, retry_cnt_o};
    endfunction

    function automatic logic [8:0] model_vec();
        return {(m_phase == PH_HOLD) || (m_phase == PH_FAULT),
                !((m_phase == PH_REL) || (m_phase == PH_RUN)),
                m_phase != PH_RUN, m_phase == PH_RUN, m_phase == PH_FAULT, 4'(m_retry)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL model t=%0t: got pll,ser,pix,lck,flt,retry=%b want %b",
                     $time, dut_vec(), model_vec());
        end
        checks++;
        if ((!pix_reset_o && ser_reset_o) || (!ser_reset_o && pll_reset_o) ||
            (locked_o && pix_reset_o) || (pll_reset_o && (!ser_reset_o || !pix_reset_o))) begin
            errors++;
            $display("FAIL invariant t=%0t: got pll,ser,pix,lck=%b%b%b%b which breaks reset ordering",
                     $time, pll_reset_o, ser_reset_o, pix_reset_o, locked_o);
        end
    endtask

    typedef struct {
        int rst; int relock; int lock; int n;
        int pll; int ser; int pix; int lck; int flt; int retry;
    } vec_t;

    vec_t vecs [43];
    vec_t v;
    logic [8:0] want;
    int hold;
    int sel;

    initial begin
        reset = 1'b1; relock_req = 1'b0; pll_lock_i = 1'b0;
        vecs = '{
            // reset asserted mid REL_SER with lock already high
            '{1,0,1,2,   1,1,1,0,0,0},
            '{0,0,1,11,  0,1,1,0,0,0},
            '{0,0,1,1,   0,0,1,0,0,0},
            '{1,0,1,1,   1,1,1,0,0,0},
            // clean bring-up: 4 reset cycles, lock 10 cycles later
            '{1,0,0,1,   1,1,1,0,0,0},
            '{0,0,0,3,   1,1,1,0,0,0},
            '{0,0,0,1,   0,1,1,0,0,0},
            '{0,0,0,10,  0,1,1,0,0,0},
            '{0,0,1,9,   0,1,1,0,0,0},
            '{0,0,1,1,   0,0,1,0,0,0},
            '{0,0,1,2,   0,0,1,0,0,0},
            '{0,0,1,1,   0,0,0,1,0,0},
            // lock loss in RUN, then relock
            '{0,0,0,2,   0,0,0,1,0,0},
            '{0,0,0,1,   1,1,1,0,0,0},
            '{0,0,1,11,  0,1,1,0,0,0},
            '{0,0,1,1,   0,0,1,0,0,0},
            '{0,0,1,3,   0,0,0,1,0,0},
            // relock, then a one-cycle lock glitch during STABLE
            '{0,1,1,1,   1,1,1,0,0,0},
            '{0,0,1,5,   0,1,1,0,0,0},
            '{0,0,1,1,   0,1,1,0,0,0},
            '{0,0,0,1,   0,1,1,0,0,0},
            '{0,0,1,5,   0,1,1,0,0,0},
            '{0,0,1,4,   0,1,1,0,0,0},
            '{0,0,1,1,   0,0,1,0,0,0},
            // lock never arrives: three timeouts into FAULT
            '{1,0,0,1,   1,1,1,0,0,0},
            '{0,0,0,103, 0,1,1,0,0,0},
            '{0,0,0,1,   1,1,1,0,0,1},
            '{0,0,0,3,   1,1,1,0,0,1},
            '{0,0,0,1,   0,1,1,0,0,1},
            '{0,0,0,99,  0,1,1,0,0,1},
            '{0,0,0,1,   1,1,1,0,0,2},
            '{0,0,0,4,   0,1,1,0,0,2},
            '{0,0,0,99,  0,1,1,0,0,2},
            '{0,0,0,1,   1,1,1,0,1,3},
            '{0,0,1,20,  1,1,1,0,1,3},
            // relock out of FAULT; later relock coincides with a timeout
            '{0,1,0,1,   1,1,1,0,0,0},
            '{0,0,0,4,   0,1,1,0,0,0},
            '{0,0,0,100, 1,1,1,0,0,1},
            '{0,0,0,4,   0,1,1,0,0,1},
            '{0,0,0,99,  0,1,1,0,0,1},
            '{0,1,0,1,   1,1,1,0,0,0},
            '{0,0,0,4,   0,1,1,0,0,0},
            '{0,0,0,100, 1,1,1,0,0,1}
        };

        for (int i = 0; i < 43; i++) begin
            v = vecs[i];
            reset      = v.rst[0];
            relock_req = v.relock[0];
            pll_lock_i = v.lock[0];
            for (int k = 0; k < v.n; k++) tick();
            want = {v.pll[0], v.ser[0], v.pix[0], v.lck[0], v.flt[0], v.retry[3:0]};
            checks++;
            if (dut_vec() !== want) begin
                errors++;
                $display("FAIL vec%0d: got pll,ser,pix,lck,flt,retry=%b want %b", i, dut_vec(), want);
            end
        end

        // Randomized lock behaviour with occasional relock and reset.
        reset = 1'b0; relock_req = 1'b0; hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold <= 0) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 6) begin
                    pll_lock_i = 1'b1; hold = int'($urandom_range(5, 80));
                end else if (sel < 9) begin
                    pll_lock_i = 1'b0; hold = int'($urandom_range(1, 6));
                end else begin
                    pll_lock_i = 1'b0; hold = int'($urandom_range(90, 400));
                end
            end
            relock_req = ($urandom_range(0, 299) == 0);
            reset      = ($urandom_range(0, 999) == 0);
            tick();
            hold--;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
